ibufds_offset_cal: RTL
======================

# ibufds_offset_cal

Sequential offset-calibration controller for a bank of `NCH` differential input buffers with offset-cancellation inputs (4-bit `OSC` code, 2-bit `OSC_EN`). Channels are calibrated one at a time. For the active channel, the block forces calibration mode (`OSC_EN=11`), sweeps the signed offset code from −35 to +35 in steps of 5, majority-samples the synchronised buffer output, and stores the first code at which the output trips high. It sits between the PHY input buffers and the DDR3 training sequencer, which issues `start` and waits for `done`.

## Interface
- `NCH`, 8, number of buffer channels (1..32).
- `SETTLE`, 4, cycles waited after each code change before sampling (≥2; covers synchroniser latency).
- `NSAMP`, 8, samples taken per code (power of 2, ≥2).

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  — sole clock.
- `rst`  in  1  — synchronous, active-high reset.
- `start`  in  1  — single-cycle request; ignored unless idle.
- `ch_o`  in  NCH  — buffer `O` outputs; asynchronous to `clk`.
- `osc`  out  4*NCH  — per-channel offset code, channel c in `[4c+3:4c]`; registered.
- `osc_en`  out  2*NCH  — per-channel enable, channel c in `[2c+1:2c]`; registered.
- `cal_code`  out  4*NCH  — stored result per channel.
- `cal_fail`  out  NCH  — per-channel: no valid trip point found.
- `busy`  out  1  — calibration in progress.
- `done`  out  1  — one-cycle completion pulse.

## Operation
- **Code encoding**: bit3 = sign (1 = positive), `[2:0]` = magnitude; offset = ±5·mag. Zero is always emitted as `4'b1000`.
- **Sweep index**: k = 0..14 maps to v = k−7. For v<0 the code is `{1'b0, -v}`; for v≥0 it is `{1'b1, v}`.
- **FSM**: IDLE → SETTLE → SAMPLE → EVAL → (SETTLE | NEXT_CH) → (SETTLE | DONE) → IDLE.
- **IDLE**: on `start`, clear channel counter and k; enter SETTLE with channel 0 active.
- **SETTLE**: waits `SETTLE` cycles.
- **SAMPLE**: counts ones of synchronised `ch_o[ch]` over `NSAMP` cycles. The counter is log2(NSAMP)+1 bits.
- **EVAL** (pass = ones > NSAMP/2, strictly; a tie is not a pass):
  - pass with k=0: `cal_fail[ch]=1`, `cal_code[ch]=1000` (already saturated); go to NEXT_CH.
  - pass with k>0: `cal_code[ch]` = code(k), `cal_fail[ch]=0`; go to NEXT_CH.
  - no pass with k=14: `cal_fail[ch]=1`, `cal_code[ch]=1000`; go to NEXT_CH.
  - otherwise: k++, update `osc[ch]`, return to SETTLE.
- **NEXT_CH** (1 cycle): active channel gets `osc_en=00` and `osc=cal_code[ch]`. If ch = NCH−1, go to DONE. Otherwise ch++, k=0, and the next channel gets `osc_en=11`, `osc=0111`; go to SETTLE.
- **DONE** (1 cycle): `done=1`, then IDLE.
- **Inactive channels**: always `osc_en=00`, `osc=cal_code[c]`. Only the active channel sees `osc_en=11`.
- **Enable encoding**: `osc_en` never takes 01 or 10. Both bits switch together on one edge.
- **Re-run**: a new `start` overwrites all codes and fail flags.

## Timing
- **Reset values**: `osc` all `1000`, `osc_en` all `00`, `cal_code` all `1000`, `cal_fail` 0, `busy` 0, `done` 0, FSM IDLE. The same values apply when `rst` is asserted mid-sweep; no partial result is retained.
- **Start**: `start` sampled in cycle c0. Channel 0 `osc_en=11`, `osc=0111`, and `busy=1` are visible from c0+1.
- **Per code step**: SETTLE+NSAMP+1 cycles.
- **Per channel**: steps(ch)·(SETTLE+NSAMP+1)+1 cycles, where steps = k_final+1.
- **Completion**: `done` is high in cycle c0 + 1 + Σ_ch[steps(ch)·(SETTLE+NSAMP+1)+1]. `busy` falls in the same cycle `done` rises.
- **Start while busy**: ignored. Start coincident with `rst`: `rst` wins.
- **Synchroniser**: 2 flops per `ch_o` bit. Samples in SAMPLE are therefore taken ≥SETTLE−2 cycles after the code reached the pad.

## Structure
- **Shared package `ibufds_cal_pkg`**:
  - OSC_EN encodings: `OSC_EN_OFF=2'b00`, `OSC_EN_CAL=2'b11`.
  - `OSC_ZERO=4'b1000`, `K_MAX=14`.
  - FSM state localparams.
  - Function `k2code(k)` mapping sweep index to code.
- **Sub-module**: one, `sync2` (2-flop synchroniser, width `NCH`). Everything else is flat in `ibufds_offset_cal`.

## Test plan
Bench model per channel: O=1 if offset+v>0, O=0 if <0, toggles each cycle if =0. Use NCH=2, SETTLE=4, NSAMP=8 unless noted.

1. Offsets {+12, −8}, start at c0 → ch0 code `0010` (v=−2, 6 steps), ch1 code `1010` (v=+2, 10 steps), fail=00, `done` exactly at c0+211.
2. Offsets {+40, −40} → both `cal_fail=1`, both `cal_code=1000`. ch0 resolves after 1 step; ch1 after 15 steps.
3. Offset 0 (toggling at v=0, 4/8 ones, no pass) → code `1001` (v=+1). Offset −5 → `1010`.
4. Assert `rst` during ch1 SAMPLE → next cycle all outputs at reset values. A following `start` completes a normal run with correct codes.
5. Pulse `start` repeatedly while busy → `done` count = 1, timing unchanged. Assertion over the whole run: no `osc_en` field is ever 01/10, and at most one channel is at 11.
6. Run twice with offsets {+12, −8}, then {−12, +8} → second-run codes `1011`, `0001`. During ch1 sweep, ch0 `osc` holds `1011` with `osc_en=00`.

Source files
------------

// File: rtl/ibufds_offset_cal_pkg.sv
// Shared definitions for the IBUFDS offset-calibration controller:
// enable encodings, code constants, FSM states and the sweep-index-to-code map.
package ibufds_cal_pkg;

  localparam logic [1:0] OSC_EN_OFF = 2'b00;
  localparam logic [1:0] OSC_EN_CAL = 2'b11;
  localparam logic [3:0] OSC_ZERO   = 4'b1000;
  localparam int         K_MAX      = 14;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_EVAL,
    S_NEXT_CH,
    S_DONE
  } state_t;

  // Index k sweeps v = k-7; negative offsets carry sign bit 0, zero is always positive.
  function automatic logic [3:0] k2code(input logic [3:0] k);
    logic [3:0] mag;
    if (k < 4'd7) begin
      mag = 4'd7 - k;
      return {1'b0, mag[2:0]};
    end else begin
      mag = k - 4'd7;
      return {1'b1, mag[2:0]};
    end
  endfunction

endpackage

// File: rtl/ibufds_offset_cal_if.sv
// Sequencer-facing handshake and result bus of the offset-calibration controller.
interface ibufds_offset_cal_if #(parameter int NCH = 8);

  logic             start;
  logic             busy;
  logic             done;
  logic [4*NCH-1:0] cal_code;
  logic [NCH-1:0]   cal_fail;

  modport master (output start, input busy, done, cal_code, cal_fail);
  modport slave  (input start, output busy, done, cal_code, cal_fail);

endinterface

// File: rtl/ibufds_offset_cal_sync2.sv
// Two-flop synchroniser bringing the asynchronous buffer outputs into the clk domain.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ibufds_offset_cal.sv
// Sweeps each buffer's offset code from -35 to +35, majority-samples the buffer
// output per code and records the first code at which it trips high.
module ibufds_offset_cal
  import ibufds_cal_pkg::*;
#(
  parameter int NCH    = 8,
  parameter int SETTLE = 4,
  parameter int NSAMP  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NCH-1:0]      ch_o,
  output logic [4*NCH-1:0]    osc,
  output logic [2*NCH-1:0]    osc_en,
  ibufds_offset_cal_if.slave  cal
);

  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int SW  = $clog2(SETTLE);
  localparam int SNW = $clog2(NSAMP);
  localparam int NW  = $clog2(NSAMP) + 1;

  state_t           state;
  logic [CW-1:0]    ch;
  logic [3:0]       k;
  logic [SW-1:0]    settle_cnt;
  logic [SNW-1:0]   samp_cnt;
  logic [NW-1:0]    ones;
  logic [NCH-1:0]   o_sync;
  logic [4*NCH-1:0] code_q;
  logic [NCH-1:0]   fail_q;
  logic             busy_q;
  logic             done_q;
  logic             pass;

  sync2 #(.WIDTH(NCH)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (ch_o),
    .q   (o_sync)
  );

  // A tie between ones and zeros is treated as "not yet tripped".
  assign pass = ones > NW'(NSAMP / 2);

  assign cal.busy     = busy_q;
  assign cal.done     = done_q;
  assign cal.cal_code = code_q;
  assign cal.cal_fail = fail_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      ch         <= '0;
      k          <= '0;
      settle_cnt <= '0;
      samp_cnt   <= '0;
      ones       <= '0;
      osc        <= {NCH{OSC_ZERO}};
      osc_en     <= {NCH{OSC_EN_OFF}};
      code_q     <= {NCH{OSC_ZERO}};
      fail_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cal.start) begin
            ch          <= '0;
            k           <= '0;
            settle_cnt  <= '0;
            busy_q      <= 1'b1;
            osc[3:0]    <= k2code(4'd0);
            osc_en[1:0] <= OSC_EN_CAL;
            state       <= S_SETTLE;
          end
        end

        S_SETTLE: begin
          if (settle_cnt == SW'(SETTLE - 1)) begin
            samp_cnt <= '0;
            ones     <= '0;
            state    <= S_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end

        S_SAMPLE: begin
          ones <= ones + NW'(o_sync[ch]);
          if (samp_cnt == SNW'(NSAMP - 1)) begin
            state <= S_EVAL;
          end else begin
            samp_cnt <= samp_cnt + 1'b1;
          end
        end

        // Tripping at the very first code means the offset is beyond the sweep range.
        S_EVAL: begin
          if (pass || (k == 4'(K_MAX))) begin
            code_q[4*ch +: 4] <= (pass && (k != 4'd0)) ? k2code(k) : OSC_ZERO;
            fail_q[ch]        <= !(pass && (k != 4'd0));
            state             <= S_NEXT_CH;
          end else begin
            k              <= k + 4'd1;
            osc[4*ch +: 4] <= k2code(k + 4'd1);
            settle_cnt     <= '0;
            state          <= S_SETTLE;
          end
        end

        S_NEXT_CH: begin
          osc_en[2*ch +: 2] <= OSC_EN_OFF;
          osc[4*ch +: 4]    <= code_q[4*ch +: 4];
          if (ch == CW'(NCH - 1)) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= S_DONE;
          end else begin
            ch                           <= ch + CW'(1);
            k                            <= '0;
            settle_cnt                   <= '0;
            osc_en[2*(ch + CW'(1)) +: 2] <= OSC_EN_CAL;
            osc[4*(ch + CW'(1)) +: 4]    <= k2code(4'd0);
            state                        <= S_SETTLE;
          end
        end

        S_DONE: state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
